gac_sched: RTL

- Gate-control scheduler that drives the scm send window: `gac2scm_sent_start` and `gac2scm_sent_end`.
- Runs a programmable periodic cycle. It opens and closes up to NUM_WIN transmission windows per cycle from a software-written gate control list.
- Configured and read back over the 134-bit control channel, using the same flit format as scm.
- Sits beside scm in the pipeline, on the control chain.

---
 rtl/gac_sched.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/gac_sched.sv
// gac_sched: gate-control scheduler for the scm send window.
// Runs a programmable periodic cycle and opens/closes up to NUM_WIN windows
// per cycle from a software-written gate control list, signalling scm with
// one-cycle gac2scm_sent_start / gac2scm_sent_end pulses. Configured and read
// back over the 134-bit control flit channel.
// Optional build macro: GAC_WIN_STATS_EN adds the WIN_CNT start-pulse counter
// at register 0x05 (reads 0 and ignores writes when undefined).
module gac_sched #(
   parameter int NUM_WIN = 4,
   parameter int CNT_W   = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [133:0] cin_gac_data,
   input  logic         cin_gac_data_wr,
   output logic         cout_gac_ready,
   output logic [133:0] cout_gac_data,
   output logic         cout_gac_data_wr,
   input  logic         cin_gac_ready,
   output logic         gac2scm_sent_start,
   output logic         gac2scm_sent_end
);

   localparam int IDX_W = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CLOSED = 2'd1,
      OPEN   = 2'd2,
      DRAIN  = 2'd3
   } state_e;

   // Control flit fields
   logic [5:0]  flit_hdr;
   logic [3:0]  flit_cmd;
   logic [31:0] flit_addr;
   logic [31:0] flit_wdata;
   logic [7:0]  reg_a;
   logic        flit_acc;
   logic        wr_en;
   logic        rd_en;
   logic        unused_flit;

   assign flit_hdr    = cin_gac_data[133:128];
   assign flit_cmd    = cin_gac_data[127:124];
   assign flit_addr   = cin_gac_data[95:64];
   assign flit_wdata  = cin_gac_data[31:0];
   assign reg_a       = flit_addr[7:0];
   assign unused_flit = &{1'b0, cin_gac_data[123:96], cin_gac_data[63:32]};

   assign flit_acc = cin_gac_data_wr & cout_gac_ready & (flit_hdr[5:4] == 2'b01);
   assign wr_en    = flit_acc & (flit_cmd == 4'hA);
   assign rd_en    = flit_acc & (flit_cmd == 4'h9);

   // Configuration and schedule state
   logic             enable_q;
   logic [CNT_W-1:0] cycle_len_q;     // length in force for the running cycle
   logic [CNT_W-1:0] cycle_len_sh_q;  // last written length, applied at wrap
   logic [CNT_W-1:0] win_start_q [NUM_WIN];
   logic [CNT_W-1:0] win_end_q   [NUM_WIN];
   logic [133:0]     resp_q;
   logic             resp_vld_q;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] cur_q, cur_d;
   logic             pend_q, pend_d;
   logic [IDX_W-1:0] pend_idx_q, pend_idx_d;

   logic             start_pulse;
   logic             end_pulse;
   logic [NUM_WIN-1:0] win_vld;
   logic             start_hit, chain_hit, end_hit, wrap;
   logic [IDX_W-1:0] start_idx, chain_idx;
   logic [CNT_W:0]   cnt_inc;
   logic [31:0]      rd_data;

`ifdef GAC_WIN_STATS_EN
   logic [31:0] win_cnt_q;

   // Saturating count of window openings; any write to 0x05 clears it
   always_ff @(posedge clk) begin
      if (rst) begin
         win_cnt_q <= '0;
      end else if (wr_en && reg_a == 8'h05) begin
         win_cnt_q <= '0;
      end else if (start_pulse && win_cnt_q != 32'hFFFF_FFFF) begin
         win_cnt_q <= win_cnt_q + 32'd1;
      end
   end
`endif

   // Software-visible registers written by accepted write flits
   // NOTE: state is updated only with non-blocking assignments so every
   // always_ff sees the pre-edge values of the others, whatever their order.
   always_ff @(posedge clk) begin
      if (rst) begin
         enable_q       <= 1'b0;
         cycle_len_q    <= '0;
         cycle_len_sh_q <= '0;
         // NOTE: the window table is reset like any register: its contents
         // feed window validity and are read back, so X after reset is unsafe.
         for (int i = 0; i < NUM_WIN; i++) begin
            win_start_q[i] <= '0;
            win_end_q[i]   <= '0;
         end
      end else begin
         if (wr_en && reg_a == 8'h00) enable_q <= flit_wdata[0];
         if (wr_en && reg_a == 8'h01) cycle_len_sh_q <= CNT_W'(flit_wdata);
         // Idle: a new length applies at once; running: only at the wrap
         if (wr_en && reg_a == 8'h01 && state_q == IDLE) begin
            cycle_len_q <= CNT_W'(flit_wdata);
         end else if (state_q == IDLE || ((state_q == CLOSED || state_q == OPEN) && wrap)) begin
            cycle_len_q <= cycle_len_sh_q;
         end
         for (int i = 0; i < NUM_WIN; i++) begin
            if (wr_en && reg_a == 8'(8 + 2 * i)) win_start_q[i] <= CNT_W'(flit_wdata);
            if (wr_en && reg_a == 8'(9 + 2 * i)) win_end_q[i]   <= CNT_W'(flit_wdata);
         end
      end
   end

   // Window validity and start/end match search; lowest index wins
   // NOTE: every signal driven here gets a default before any condition, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      win_vld   = '0;
      start_hit = 1'b0;
      start_idx = '0;
      chain_hit = 1'b0;
      chain_idx = '0;
      for (int i = NUM_WIN - 1; i >= 0; i--) begin
         win_vld[i] = (win_start_q[i] < win_end_q[i]) && (win_end_q[i] <= cycle_len_q)
                      && (cycle_len_q != '0);
         if (win_vld[i] && cnt_q == win_start_q[i]) begin
            start_hit = 1'b1;
            start_idx = IDX_W'(i);
            if (IDX_W'(i) != cur_q) begin
               chain_hit = 1'b1;
               chain_idx = IDX_W'(i);
            end
         end
      end
   end

   assign cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);
   assign wrap    = cnt_inc >= {1'b0, cycle_len_q};
   // cnt==0 while OPEN can only follow a wrap: that closes a window ending at CYCLE_LEN
   assign end_hit = (cnt_q == win_end_q[cur_q]) || (cnt_q == '0) || !win_vld[cur_q];

   // Scheduler next state, cycle counter and pulse outputs
   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      pend_d      = pend_q;
      pend_idx_d  = pend_idx_q;
      start_pulse = 1'b0;
      end_pulse   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (enable_q) state_d = CLOSED;
         end
         CLOSED: begin
            pend_d = 1'b0;
            if (!enable_q) begin
               state_d = IDLE;
            end else if (pend_q && win_vld[pend_idx_q]) begin
               // Start deferred from the previous cycle's end
               start_pulse = 1'b1;
               state_d     = OPEN;
               cur_d       = pend_idx_q;
            end else if (start_hit) begin
               start_pulse = 1'b1;
               state_d     = OPEN;
               cur_d       = start_idx;
            end
         end
         OPEN: begin
            if (!enable_q) begin
               state_d = DRAIN;
            end else if (end_hit) begin
               end_pulse  = 1'b1;
               state_d    = CLOSED;
               pend_d     = chain_hit;
               pend_idx_d = chain_idx;
            end
         end
         DRAIN: begin
            end_pulse = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (state_d == IDLE || state_q == IDLE || wrap) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_inc[CNT_W-1:0];
      end
   end

   // Scheduler state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         cur_q      <= '0;
         pend_q     <= 1'b0;
         pend_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cur_q      <= cur_d;
         pend_q     <= pend_d;
         pend_idx_q <= pend_idx_d;
      end
   end

   // Register read mux for read flits
   always_comb begin
      rd_data = '0;
      case (reg_a)
         8'h00: rd_data = {31'd0, enable_q};
         8'h01: rd_data = 32'(cycle_len_sh_q);
         8'h02: rd_data = 32'(cnt_q);
         8'h03: rd_data = {30'd0, state_q};
`ifdef GAC_WIN_STATS_EN
         8'h05: rd_data = win_cnt_q;
`endif
         default: rd_data = '0;
      endcase
      for (int i = 0; i < NUM_WIN; i++) begin
         if (reg_a == 8'(8 + 2 * i)) rd_data = 32'(win_start_q[i]);
         if (reg_a == 8'(9 + 2 * i)) rd_data = 32'(win_end_q[i]);
      end
   end

   // Read response: built on acceptance, held until downstream takes it
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_q     <= '0;
         resp_vld_q <= 1'b0;
      end else if (rd_en) begin
         resp_q     <= {flit_hdr, 4'hB, 28'd0, flit_addr, 32'd0, rd_data};
         resp_vld_q <= 1'b1;
      end else if (resp_vld_q && cin_gac_ready) begin
         resp_vld_q <= 1'b0;
      end
   end

   assign cout_gac_ready     = ~resp_vld_q;
   assign cout_gac_data      = resp_q;
   assign cout_gac_data_wr   = resp_vld_q;
   assign gac2scm_sent_start = start_pulse;
   assign gac2scm_sent_end   = end_pulse;

endmodule
